sync_tx_arbiter: RTL and testbench

SYNC_TX_ARBITER -- requirements
Module: sync_tx_arbiter

---
 rtl/sync_tx_arbiter_if.sv | 35 +++
 rtl/sync_tx_arbiter.sv | 158 +++++++++++++++
 tb/tb_sync_tx_arbiter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/sync_tx_arbiter_if.sv
// Requester/synchroniser bundle for sync_tx_arbiter; carries no logic.
// Latency: none (wires only).
// Backpressure: requesters hold req until gnt; there is no ready path to the synchroniser side.
interface sync_tx_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int BUS_WIDTH = 8
);
    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ*BUS_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]           gnt;
    logic [BUS_WIDTH-1:0]         Unsync_bus;
    logic                         bus_enable;
    logic                         busy;
    logic                         done;

    modport master (
        input  req,
        input  req_data,
        output gnt,
        output Unsync_bus,
        output bus_enable,
        output busy,
        output done
    );

    modport slave (
        output req,
        output req_data,
        input  gnt,
        input  Unsync_bus,
        input  bus_enable,
        input  busy,
        input  done
    );
endinterface

// File: rtl/sync_tx_arbiter.sv
// Arbitrates NUM_REQ requesters onto one bus_enable synchroniser channel; ARB_ROUND_ROBIN_EN selects round-robin, else fixed priority.
// Latency: gnt/bus_enable one edge after req sampled in IDLE; enable HOLD_CYCLES high, GAP_CYCLES low, then done.
// Backpressure: req is level and held until gnt; requests seen only in IDLE, no request is lost while held.
module sync_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int BUS_WIDTH   = 8,
    parameter int HOLD_CYCLES = 6,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                CLK,
    input  logic                RST,
    sync_tx_arbiter_if.master   intf
);

    localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam int PTR_W   = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [BUS_WIDTH-1:0] bus_q, bus_d;
    logic                 en_q, en_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 found;
    logic [PTR_W-1:0]     cand;
    logic [PTR_W-1:0]     win_idx;
    logic [BUS_WIDTH-1:0] win_data;

`ifdef ARB_ROUND_ROBIN_EN
    logic [PTR_W-1:0]     ptr_q, ptr_d;
`endif

    // Winner search: starts at the pointer in round-robin, at index 0 otherwise.
    always_comb begin
        found   = 1'b0;
        cand    = '0;
        win_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            cand = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
`else
            cand = PTR_W'(k);
`endif
            if (!found && intf.req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win_idx == PTR_W'(k)) begin
                win_data = intf.req_data[k*BUS_WIDTH +: BUS_WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = '0;
        bus_d   = bus_q;
        en_d    = en_q;
        done_d  = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d   = NUM_REQ'(1) << win_idx;
                    bus_d   = win_data;
                    en_d    = 1'b1;
                    cnt_d   = CNT_W'(1);
                    state_d = HOLD;
`ifdef ARB_ROUND_ROBIN_EN
                    ptr_d   = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
`endif
                end
            end
            // cnt counts the cycle currently being spent in the phase, starting at 1.
            HOLD: begin
                if (cnt_q == CNT_W'(HOLD_CYCLES)) begin
                    en_d    = 1'b0;
                    cnt_d   = CNT_W'(1);
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == CNT_W'(GAP_CYCLES)) begin
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                en_d    = 1'b0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gnt_q   <= '0;
            bus_q   <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            bus_q   <= bus_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign intf.gnt        = gnt_q;
    assign intf.Unsync_bus = bus_q;
    assign intf.bus_enable = en_q;
    assign intf.busy       = busy_q;
    assign intf.done       = done_q;

    a_gnt_onehot: assert property (@(posedge CLK) disable iff (!RST) $onehot0(gnt_q));

endmodule

// File: tb/tb_sync_tx_arbiter.sv
// Directed bench for sync_tx_arbiter: single-grant timing, multi-requester order, mid-transfer reset, dropped requests.
module tb_sync_tx_arbiter;
    localparam int NR = 4;
    localparam int BW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sync_tx_arbiter_if #(.NUM_REQ(NR), .BUS_WIDTH(BW)) bus_if ();

    sync_tx_arbiter #(
        .NUM_REQ(NR), .BUS_WIDTH(BW), .HOLD_CYCLES(6), .GAP_CYCLES(2)
    ) dut (
        .CLK  (clk),
        .RST  (rst_n),
        .intf (bus_if.master)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3);
        bus_if.req_data = {d3, d2, d1, d0};
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        bus_if.req = '0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic wait_gnt(output logic [3:0] g, output logic [7:0] b, output int lat);
        lat = 0;
        g   = '0;
        b   = '0;
        while (g == 4'b0 && lat < 40) begin
            step();
            lat++;
            g = bus_if.gnt;
            b = bus_if.Unsync_bus;
        end
    endtask

    // Starts on the grant sample; ends on the sample where done is high.
    task automatic watch_xfer(input logic [7:0] exp_bus, input int raise_at,
                              input logic [3:0] raise_mask,
                              output int hi, output int lo, output int bad);
        int guard;
        guard = 0;
        bad   = 0;
        hi    = bus_if.bus_enable ? 1 : 0;
        while (bus_if.bus_enable && guard < 50) begin
            step();
            guard++;
            if (bus_if.gnt != 4'b0 || bus_if.Unsync_bus !== exp_bus) bad++;
            if (bus_if.bus_enable) begin
                hi++;
                if (hi == raise_at) bus_if.req = bus_if.req | raise_mask;
            end
        end
        lo = 0;
        while (!bus_if.done && guard < 50) begin
            if (!bus_if.bus_enable) lo++;
            step();
            guard++;
            if (bus_if.gnt != 4'b0 || bus_if.Unsync_bus !== exp_bus) bad++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] g;
        logic [7:0] b;
        int lat, hi, lo, bad, stray;
        logic [3:0] exp_seq [3];

        bus_if.req      = '0;
        bus_if.req_data = '0;

        // Basic single transfer
        do_reset();
        check("rst_gnt",  32'(bus_if.gnt), 32'h0);
        check("rst_bus",  32'(bus_if.Unsync_bus), 32'h0);
        check("rst_en",   32'(bus_if.bus_enable), 32'h0);
        check("rst_busy", 32'(bus_if.busy), 32'h0);
        check("rst_done", 32'(bus_if.done), 32'h0);
        set_data(8'hF0, 8'h00, 8'h00, 8'h00);
        bus_if.req = 4'b0001;
        wait_gnt(g, b, lat);
        check("t1_lat",  32'(lat), 32'd1);
        check("t1_gnt",  32'(g), 32'h1);
        check("t1_bus",  32'(b), 32'hF0);
        check("t1_en",   32'(bus_if.bus_enable), 32'h1);
        check("t1_busy", 32'(bus_if.busy), 32'h1);
        bus_if.req = '0;
        watch_xfer(8'hF0, 0, 4'b0, hi, lo, bad);
        check("t1_hold", 32'(hi), 32'd6);
        check("t1_gap",  32'(lo), 32'd2);
        check("t1_stab", 32'(bad), 32'd0);
        check("t1_done", 32'(bus_if.done), 32'h1);
        check("t1_idle", 32'(bus_if.busy), 32'h0);
        step();
        check("t1_done_pulse", 32'(bus_if.done), 32'h0);

        // All four requesting, each drops after its grant
        do_reset();
        set_data(8'h10, 8'h11, 8'h12, 8'h13);
        bus_if.req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            wait_gnt(g, b, lat);
            check($sformatf("t2_gnt%0d", i), 32'(g), 32'(4'b0001 << i));
            check($sformatf("t2_bus%0d", i), 32'(b), 32'(8'h10 + i));
            check($sformatf("t2_lat%0d", i), 32'(lat), 32'd1);
            bus_if.req = bus_if.req & ~g;
            watch_xfer(8'(8'h10 + i), 0, 4'b0, hi, lo, bad);
            check($sformatf("t2_hold%0d", i), 32'(hi), 32'd6);
            check($sformatf("t2_gap%0d", i), 32'(lo), 32'd2);
            check($sformatf("t2_stab%0d", i), 32'(bad), 32'd0);
        end

        // Requester 0 re-raises right after each grant
`ifdef ARB_ROUND_ROBIN_EN
        exp_seq = '{4'b0001, 4'b0010, 4'b0100};
`else
        exp_seq = '{4'b0001, 4'b0001, 4'b0001};
`endif
        do_reset();
        set_data(8'h10, 8'h11, 8'h12, 8'h13);
        bus_if.req = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            wait_gnt(g, b, lat);
            check($sformatf("t3_gnt%0d", i), 32'(g), 32'(exp_seq[i]));
            bus_if.req = bus_if.req & ~g;
            watch_xfer(b, 2, 4'b0001, hi, lo, bad);
            check($sformatf("t3_stab%0d", i), 32'(bad), 32'd0);
        end

        // Request arriving mid-HOLD is served right after done
        do_reset();
        set_data(8'h55, 8'h00, 8'hAA, 8'h00);
        bus_if.req = 4'b0001;
        wait_gnt(g, b, lat);
        check("t4_gnt0", 32'(g), 32'h1);
        bus_if.req = '0;
        watch_xfer(8'h55, 3, 4'b0100, hi, lo, bad);
        check("t4_stab", 32'(bad), 32'd0);
        check("t4_hold", 32'(hi), 32'd6);
        wait_gnt(g, b, lat);
        check("t4_gnt2", 32'(g), 32'h4);
        check("t4_lat",  32'(lat), 32'd1);
        check("t4_bus",  32'(b), 32'hAA);
        check("t4_nodone", 32'(bus_if.done), 32'h0);
        bus_if.req = '0;

        // Reset during the third HOLD cycle
        do_reset();
        set_data(8'h33, 8'h00, 8'h00, 8'h77);
        bus_if.req = 4'b0001;
        wait_gnt(g, b, lat);
        bus_if.req = '0;
        step();
        step();
        check("t5_en_h3", 32'(bus_if.bus_enable), 32'h1);
        rst_n = 1'b0;
        #1;
        check("t5_en",   32'(bus_if.bus_enable), 32'h0);
        check("t5_bus",  32'(bus_if.Unsync_bus), 32'h0);
        check("t5_busy", 32'(bus_if.busy), 32'h0);
        stray = 0;
        for (int i = 0; i < 2; i++) begin
            step();
            if (bus_if.done) stray++;
        end
        rst_n      = 1'b1;
        bus_if.req = 4'b1000;
        wait_gnt(g, b, lat);
        if (bus_if.done) stray++;
        check("t5_nodone", 32'(stray), 32'd0);
        check("t5_gnt3", 32'(g), 32'h8);
        check("t5_lat",  32'(lat), 32'd1);
        check("t5_bus3", 32'(b), 32'h77);
        bus_if.req = '0;

        // One-cycle req pulse during GAP is never served
        do_reset();
        set_data(8'h44, 8'h99, 8'h00, 8'h00);
        bus_if.req = 4'b0001;
        wait_gnt(g, b, lat);
        bus_if.req = '0;
        for (int i = 0; i < 6; i++) step();
        check("t6_in_gap", 32'({bus_if.bus_enable, bus_if.busy}), 32'b01);
        bus_if.req = 4'b0010;
        step();
        bus_if.req = '0;
        step();
        check("t6_done", 32'(bus_if.done), 32'h1);
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus_if.gnt != 4'b0 || bus_if.busy || bus_if.bus_enable) stray++;
        end
        check("t6_no_gnt", 32'(stray), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
